// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and data-memory bus of the load/store unit.
// master = core plus memory side, slave = the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [63:0] mem_read_data;
    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_address, mem_write_data, mem_write_en, mem_read_en
    );
    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_address, mem_write_data, mem_write_en, mem_read_en
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: sized, aligned loads/stores over a 64-bit data memory; sub-doubleword stores do read-modify-write.
// Define LSU_RANGE_CHECK_EN to flag accesses ending beyond MEM_BYTES as errors.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input logic              clk,
    input logic              rstn,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
    state_t      state;
    logic        write_q, uns_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q, wdata_q, old_q;
    logic [5:0]  sh;
    logic [63:0] lane, mask, shifted, load_data;
    logic [2:0]  align_mask;
    logic        err;

    if (MEM_BYTES < 8 || (MEM_BYTES & (MEM_BYTES - 1)) != 0) begin : g_bad_size
        $error("MEM_BYTES must be a power of two, at least 8");
    end

    assign sh         = {addr_q[2:0], 3'b000};
    assign lane       = size_q == 2'd0 ? 64'hFF : size_q == 2'd1 ? 64'hFFFF :
                        size_q == 2'd2 ? 64'hFFFF_FFFF : '1;
    assign mask       = lane << sh;
    assign shifted    = bus.mem_read_data >> sh;
    assign load_data  = size_q == 2'd0 ? {{56{~uns_q & shifted[7]}},  shifted[7:0]}  :
                        size_q == 2'd1 ? {{48{~uns_q & shifted[15]}}, shifted[15:0]} :
                        size_q == 2'd2 ? {{32{~uns_q & shifted[31]}}, shifted[31:0]} : shifted;
    assign align_mask = 3'((4'd1 << bus.req_size) - 4'd1);
`ifdef LSU_RANGE_CHECK_EN
    assign err = |(bus.req_addr[2:0] & align_mask) ||
                 ({1'b0, bus.req_addr} + (65'd1 << bus.req_size) > 65'(MEM_BYTES));
`else
    assign err = |(bus.req_addr[2:0] & align_mask);
`endif

    // Strobes and handshakes decode straight from the state register.
    assign bus.req_ready      = state == IDLE;
    assign bus.resp_valid     = state == RESP;
    assign bus.mem_read_en    = state == READ;
    assign bus.mem_write_en   = state == WRITE;
    assign bus.mem_address    = {addr_q[63:3], 3'b000};
    // A doubleword store has an all-ones mask, so the stale old_q drops out.
    assign bus.mem_write_data = (old_q & ~mask) | ((wdata_q << sh) & mask);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            write_q        <= 1'b0;
            uns_q          <= 1'b0;
            size_q         <= 2'd0;
            addr_q         <= '0;
            wdata_q        <= '0;
            old_q          <= '0;
            bus.resp_rdata <= '0;
            bus.resp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    write_q        <= bus.req_write;
                    uns_q          <= bus.req_unsigned;
                    size_q         <= bus.req_size;
                    addr_q         <= bus.req_addr;
                    wdata_q        <= bus.req_wdata;
                    bus.resp_rdata <= '0;
                    bus.resp_error <= err;
                    state          <= err ? RESP : (bus.req_write && bus.req_size == 2'd3) ? WRITE : READ;
                end
                READ: begin
                    if (write_q) old_q <= bus.mem_read_data;
                    else bus.resp_rdata <= load_data;
                    state <= write_q ? WRITE : RESP;
                end
                WRITE:   state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of the load/store unit against a 1 KiB memory model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rstn;
    int   vec = 0;
    int   miss = 0;
    logic [63:0] mem [128] = '{default: 64'h0};

    load_store_unit_if ifc ();
    load_store_unit #(.MEM_BYTES(1024)) dut (.clk(clk), .rstn(rstn), .bus(ifc));

    always #5 clk = ~clk;
    assign ifc.mem_read_data = mem[ifc.mem_address[9:3]];
    always @(posedge clk) if (ifc.mem_write_en) mem[ifc.mem_address[9:3]] <= ifc.mem_write_data;

    task automatic access(input logic w, input logic [1:0] sz, input logic u, input logic [63:0] a,
                          input logic [63:0] d, output logic got, output logic [63:0] rdata,
                          output logic err, output int lat, output int rd, output int wr);
        @(negedge clk);
        ifc.req_valid = 1'b1; ifc.req_write = w; ifc.req_size = sz;
        ifc.req_unsigned = u; ifc.req_addr = a; ifc.req_wdata = d;
        got = 1'b0; rdata = '0; err = 1'b0; lat = 1; rd = 0; wr = 0;
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ifc.mem_read_en) rd++;
            if (ifc.mem_write_en) wr++;
            if (ifc.resp_valid) begin
                got = 1'b1; rdata = ifc.resp_rdata; err = ifc.resp_error;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b1;
        ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_size = 2'd0;
        ifc.req_unsigned = 1'b0; ifc.req_addr = '0; ifc.req_wdata = '0;
        #2 rstn = 1'b0;
        #1;
        vec++; if (ifc.req_ready !== 1'b1) begin miss++; $display("FAIL reset_ready: got %b expected 1", ifc.req_ready); end
        vec++; if (ifc.resp_valid !== 1'b0) begin miss++; $display("FAIL reset_resp_valid: got %b expected 0", ifc.resp_valid); end
        vec++; if (ifc.resp_error !== 1'b0) begin miss++; $display("FAIL reset_resp_error: got %b expected 0", ifc.resp_error); end
        vec++; if (ifc.resp_rdata !== 64'h0) begin miss++; $display("FAIL reset_rdata: got %h expected 0", ifc.resp_rdata); end
        vec++; if ({ifc.mem_read_en, ifc.mem_write_en} !== 2'b00) begin miss++; $display("FAIL reset_strobes: got %b expected 00", {ifc.mem_read_en, ifc.mem_write_en}); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_dword;
        logic got, err; logic [63:0] rd_data; int lat, rd, wr;
        access(1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, got, rd_data, err, lat, rd, wr);
        vec++; if (got !== 1'b1) begin miss++; $display("FAIL dstore_resp: got %b expected 1", got); end
        vec++; if (err !== 1'b0) begin miss++; $display("FAIL dstore_err: got %b expected 0", err); end
        vec++; if (lat != 2) begin miss++; $display("FAIL dstore_latency: got %0d expected 2", lat); end
        vec++; if (wr != 1 || rd != 0) begin miss++; $display("FAIL dstore_strobes: got wr=%0d rd=%0d expected wr=1 rd=0", wr, rd); end
        vec++; if (mem[2] !== 64'h1122334455667788) begin miss++; $display("FAIL dstore_mem: got %h expected 1122334455667788", mem[2]); end
        access(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, got, rd_data, err, lat, rd, wr);
        vec++; if (rd_data !== 64'h1122334455667788) begin miss++; $display("FAIL dload_data: got %h expected 1122334455667788", rd_data); end
        vec++; if (err !== 1'b0) begin miss++; $display("FAIL dload_err: got %b expected 0", err); end
        vec++; if (lat != 2) begin miss++; $display("FAIL dload_latency: got %0d expected 2", lat); end
        vec++; if (rd != 1 || wr != 0) begin miss++; $display("FAIL dload_strobes: got rd=%0d wr=%0d expected rd=1 wr=0", rd, wr); end
    endtask

    task automatic test_byte_merge;
        logic got, err; logic [63:0] rd_data; int lat, rd, wr;
        access(1'b1, 2'd0, 1'b0, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, got, rd_data, err, lat, rd, wr);
        vec++; if (wr != 1 || rd != 1) begin miss++; $display("FAIL bstore_strobes: got wr=%0d rd=%0d expected wr=1 rd=1", wr, rd); end
        vec++; if (lat != 3) begin miss++; $display("FAIL bstore_latency: got %0d expected 3", lat); end
        vec++; if (err !== 1'b0 || rd_data !== 64'h0) begin miss++; $display("FAIL bstore_resp: got err=%b rdata=%h expected err=0 rdata=0", err, rd_data); end
        access(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, got, rd_data, err, lat, rd, wr);
        vec++; if (rd_data !== 64'h11223344AB667788) begin miss++; $display("FAIL bstore_merge: got %h expected 11223344ab667788", rd_data); end
    endtask

    task automatic test_extend;
        logic got, err; logic [63:0] rd_data; int lat, rd, wr;
        access(1'b1, 2'd3, 1'b0, 64'h10, 64'h80FF, got, rd_data, err, lat, rd, wr);
        access(1'b0, 2'd0, 1'b0, 64'h10, 64'h0, got, rd_data, err, lat, rd, wr);
        vec++; if (rd_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin miss++; $display("FAIL lb_signed: got %h expected ffffffffffffffff", rd_data); end
        access(1'b0, 2'd1, 1'b1, 64'h10, 64'h0, got, rd_data, err, lat, rd, wr);
        vec++; if (rd_data !== 64'h80FF) begin miss++; $display("FAIL lhu: got %h expected 00000000000080ff", rd_data); end
        access(1'b0, 2'd1, 1'b0, 64'h10, 64'h0, got, rd_data, err, lat, rd, wr);
        vec++; if (rd_data !== 64'hFFFF_FFFF_FFFF_80FF) begin miss++; $display("FAIL lh_signed: got %h expected ffffffffffff80ff", rd_data); end
        access(1'b0, 2'd0, 1'b1, 64'h11, 64'h0, got, rd_data, err, lat, rd, wr);
        vec++; if (rd_data !== 64'h80) begin miss++; $display("FAIL lbu_offset1: got %h expected 0000000000000080", rd_data); end
        repeat (3) @(negedge clk);
        vec++; if (ifc.resp_rdata !== 64'h80 || ifc.resp_valid !== 1'b0) begin miss++; $display("FAIL resp_hold: got rdata=%h valid=%b expected rdata=80 valid=0", ifc.resp_rdata, ifc.resp_valid); end
    endtask

    task automatic test_misaligned;
        logic got, err; logic [63:0] rd_data; int lat, rd, wr;
        access(1'b0, 2'd2, 1'b0, 64'h12, 64'h0, got, rd_data, err, lat, rd, wr);
        vec++; if (got !== 1'b1 || err !== 1'b1) begin miss++; $display("FAIL mis_load_err: got valid=%b err=%b expected 1 1", got, err); end
        vec++; if (rd_data !== 64'h0) begin miss++; $display("FAIL mis_load_data: got %h expected 0", rd_data); end
        vec++; if (rd != 0 || lat != 1) begin miss++; $display("FAIL mis_load_path: got rd=%0d lat=%0d expected rd=0 lat=1", rd, lat); end
        access(1'b1, 2'd1, 1'b0, 64'h11, 64'h1234, got, rd_data, err, lat, rd, wr);
        vec++; if (err !== 1'b1 || wr != 0 || rd != 0) begin miss++; $display("FAIL mis_store: got err=%b wr=%0d rd=%0d expected err=1 wr=0 rd=0", err, wr, rd); end
        vec++; if (mem[2] !== 64'h80FF) begin miss++; $display("FAIL mis_store_mem: got %h expected 80ff", mem[2]); end
    endtask

    task automatic test_range;
        logic got, err; logic [63:0] rd_data; int lat, rd, wr;
        access(1'b1, 2'd3, 1'b0, 64'h3F8, 64'h0, got, rd_data, err, lat, rd, wr);
        access(1'b1, 2'd3, 1'b0, 64'h0, 64'h12345678, got, rd_data, err, lat, rd, wr);
        access(1'b1, 2'd1, 1'b0, 64'h3FE, 64'hBEEF, got, rd_data, err, lat, rd, wr);
        vec++; if (err !== 1'b0 || wr != 1) begin miss++; $display("FAIL edge_store: got err=%b wr=%0d expected err=0 wr=1", err, wr); end
        vec++; if (mem[127] !== 64'hBEEF_0000_0000_0000) begin miss++; $display("FAIL edge_store_mem: got %h expected beef000000000000", mem[127]); end
        access(1'b0, 2'd3, 1'b0, 64'h3F8, 64'h0, got, rd_data, err, lat, rd, wr);
        vec++; if (err !== 1'b0 || rd_data !== 64'hBEEF_0000_0000_0000) begin miss++; $display("FAIL edge_load: got err=%b data=%h expected err=0 data=beef000000000000", err, rd_data); end
        access(1'b0, 2'd2, 1'b0, 64'h400, 64'h0, got, rd_data, err, lat, rd, wr);
`ifdef LSU_RANGE_CHECK_EN
        vec++; if (err !== 1'b1 || rd_data !== 64'h0 || rd != 0) begin miss++; $display("FAIL oob_load: got err=%b data=%h rd=%0d expected err=1 data=0 rd=0", err, rd_data, rd); end
`else
        vec++; if (err !== 1'b0 || rd_data !== 64'h12345678) begin miss++; $display("FAIL alias_load: got err=%b data=%h expected err=0 data=12345678", err, rd_data); end
`endif
    endtask

    task automatic test_reset_mid;
        int wr = 0, rv = 0;
        @(negedge clk);
        ifc.req_valid = 1'b1; ifc.req_write = 1'b1; ifc.req_size = 2'd0;
        ifc.req_unsigned = 1'b0; ifc.req_addr = 64'h10; ifc.req_wdata = 64'h55;
        @(posedge clk);
        #1 ifc.req_valid = 1'b0;
        @(negedge clk);
        vec++; if (ifc.mem_read_en !== 1'b1) begin miss++; $display("FAIL mid_in_read: got %b expected 1", ifc.mem_read_en); end
        rstn = 1'b0;
        #1;
        vec++; if (ifc.mem_read_en !== 1'b0 || ifc.req_ready !== 1'b1 || ifc.resp_rdata !== 64'h0) begin miss++; $display("FAIL mid_async: got rd_en=%b ready=%b rdata=%h expected 0 1 0", ifc.mem_read_en, ifc.req_ready, ifc.resp_rdata); end
        repeat (2) begin
            @(negedge clk);
            if (ifc.mem_write_en) wr++;
            if (ifc.resp_valid) rv++;
        end
        rstn = 1'b1;
        #1;
        vec++; if (ifc.req_ready !== 1'b1) begin miss++; $display("FAIL mid_ready_after: got %b expected 1", ifc.req_ready); end
        repeat (4) begin
            @(negedge clk);
            if (ifc.mem_write_en) wr++;
            if (ifc.resp_valid) rv++;
        end
        vec++; if (wr != 0 || rv != 0) begin miss++; $display("FAIL mid_no_activity: got wr=%0d resp=%0d expected 0 0", wr, rv); end
        vec++; if (mem[2] !== 64'h80FF) begin miss++; $display("FAIL mid_mem: got %h expected 80ff", mem[2]); end
    endtask

    task automatic test_back_to_back;
        logic got, err; logic [63:0] rd_data; int lat, rd, wr;
        access(1'b0, 2'd1, 1'b1, 64'h10, 64'h0, got, rd_data, err, lat, rd, wr);
        vec++; if (ifc.req_ready !== 1'b0) begin miss++; $display("FAIL resp_ready: got %b expected 0", ifc.req_ready); end
        @(posedge clk);
        #1;
        vec++; if (ifc.resp_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin miss++; $display("FAIL resp_pulse: got valid=%b ready=%b expected 0 1", ifc.resp_valid, ifc.req_ready); end
        access(1'b0, 2'd0, 1'b0, 64'h10, 64'h0, got, rd_data, err, lat, rd, wr);
        vec++; if (got !== 1'b1 || lat != 2 || rd_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin miss++; $display("FAIL b2b_load: got valid=%b lat=%0d data=%h expected 1 2 ffffffffffffffff", got, lat, rd_data); end
    endtask

    initial begin
        test_reset;
        test_dword;
        test_byte_merge;
        test_extend;
        test_misaligned;
        test_range;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
